// File: rtl/inst_wb_if_pkg.sv
// Shared encodings and constants for the instruction-side Wishbone bridge.
package inst_wb_if_pkg;

    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IF_IDLE           = 2'b00,
        IF_BUSY           = 2'b01,
        IF_WAIT_FOR_STALL = 2'b11
    } if_state_e;

    localparam logic                ZERO_WORD_BIT = 1'b0;
    localparam logic                CHIP_ENABLE   = 1'b1;
    localparam logic                CHIP_DISABLE  = 1'b0;
    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL    = 4'b1111;
    localparam logic [WB_SEL_W-1:0] WB_SEL_NONE   = 4'b0000;

endpackage

// File: rtl/inst_wb_if.sv
// Instruction-fetch Wishbone B4 classic master: one single-beat read per fetch,
// stalling the pipeline while the read is outstanding.
module inst_wb_if
    import inst_wb_if_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic                wb_ack_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_SEL_W-1:0] wb_sel_o
);

    if_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]     rd_buf_q, rd_buf_d;

    logic fetch_req;
    assign fetch_req = (cpu_ce_i == CHIP_ENABLE) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IF_IDLE;
            adr_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            sel_q    <= WB_SEL_NONE;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            sel_q    <= sel_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next-state: Wishbone signals are held in BUSY until ack or flush.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        sel_d    = sel_q;
        rd_buf_d = rd_buf_q;
        unique case (state_q)
            IF_IDLE: begin
                if (fetch_req) begin
                    adr_d   = cpu_addr_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    sel_d   = WB_SEL_ALL;
                    state_d = IF_BUSY;
                end
            end
            IF_BUSY: begin
                if (flush_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    sel_d    = WB_SEL_NONE;
                    rd_buf_d = '0;
                    state_d  = IF_IDLE;
                end else if (wb_ack_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    sel_d    = WB_SEL_NONE;
                    rd_buf_d = wb_dat_i;
                    state_d  = (stall_i != 6'd0) ? IF_WAIT_FOR_STALL : IF_IDLE;
                end
            end
            IF_WAIT_FOR_STALL: begin
                if (flush_i) begin
                    rd_buf_d = '0;
                    state_d  = IF_IDLE;
                end else if (stall_i == 6'd0) begin
                    state_d  = IF_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                sel_d   = WB_SEL_NONE;
                state_d = IF_IDLE;
            end
        endcase
    end

    // Pipeline-facing outputs; the ack word passes straight through in BUSY.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            IF_IDLE: begin
                stallreq_o = fetch_req;
                cpu_data_o = rd_buf_q;
            end
            IF_BUSY: begin
                stallreq_o = !wb_ack_i && !flush_i;
                if (wb_ack_i && !flush_i) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            IF_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stallreq_o = 1'b0;
                cpu_data_o = '0;
            end
        endcase
        if (cpu_ce_i == CHIP_DISABLE) begin
            cpu_data_o = '0;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = ZERO_WORD_BIT;
    assign wb_dat_o = '0;

endmodule

// File: tb/tb_inst_wb_if.sv
// Directed bench for inst_wb_if: hand-computed expectations checked by assertions.
module tb_inst_wb_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;

    int checks   = 0;
    int failures = 0;

    inst_wb_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_i   (wb_ack_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic cyc, input logic [31:0] adr);
        chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'(cyc));
        chk({tag, "_stb"}, 32'(wb_stb_o), 32'(cyc));
        chk({tag, "_sel"}, 32'(wb_sel_o), cyc ? 32'hF : 32'h0);
        chk({tag, "_we"},  32'(wb_we_o),  32'h0);
        chk({tag, "_dato"}, wb_dat_o,     32'h0);
        chk({tag, "_adr"}, wb_adr_o,      adr);
    endtask

    initial begin
        rst = 1'b0; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0;
        cpu_addr_i = 32'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0;
        #1;
        chk_bus("reset", 1'b0, 32'h0);
        chk("reset_stallreq", 32'(stallreq_o), 32'h0);
        chk("reset_data", cpu_data_o, 32'h0);
        step();
        step();
        rst = 1'b1;

        // Fetch 1: ack in first BUSY cycle.
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0000; #1;
        chk("f1_idle_stallreq", 32'(stallreq_o), 32'h1);
        chk_bus("f1_idle", 1'b0, 32'h0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h3401_1100; #1;
        chk_bus("f1_busy", 1'b1, 32'h0);
        chk("f1_ack_data", cpu_data_o, 32'h3401_1100);
        chk("f1_ack_stallreq", 32'(stallreq_o), 32'h0);
        step();

        // Fetch 2: three wait states, address change ignored.
        wb_ack_i = 1'b0; wb_dat_i = 32'h0; cpu_addr_i = 32'h0000_0004; #1;
        chk_bus("f2_idle", 1'b0, 32'h0);
        chk("f2_idle_data", cpu_data_o, 32'h3401_1100);
        chk("f2_idle_stallreq", 32'(stallreq_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            cpu_addr_i = 32'h0000_0100 + 32'(i); #1;
            chk_bus("f2_wait", 1'b1, 32'h0000_0004);
            chk("f2_wait_stallreq", 32'(stallreq_o), 32'h1);
            chk("f2_wait_data", cpu_data_o, 32'h0);
        end
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0020; #1;
        chk_bus("f2_ack", 1'b1, 32'h0000_0004);
        chk("f2_ack_data", cpu_data_o, 32'h0000_0020);
        chk("f2_ack_stallreq", 32'(stallreq_o), 32'h0);
        step();

        // Fetch 3: ack under pipeline stall enters WAIT_FOR_STALL.
        wb_ack_i = 1'b0; cpu_addr_i = 32'h0000_000C; #1;
        chk("f3_idle_data", cpu_data_o, 32'h0000_0020);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1122_3344; stall_i = 6'b000011; #1;
        chk_bus("f3_busy", 1'b1, 32'h0000_000C);
        chk("f3_ack_data", cpu_data_o, 32'h1122_3344);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0; #1;
        for (int i = 0; i < 2; i++) begin
            chk_bus("f3_wfs", 1'b0, 32'h0000_000C);
            chk("f3_wfs_stallreq", 32'(stallreq_o), 32'h0);
            chk("f3_wfs_data", cpu_data_o, 32'h1122_3344);
            step();
        end
        stall_i = 6'd0; cpu_addr_i = 32'h0000_0008; #1;
        chk("f3_wfs_release_stallreq", 32'(stallreq_o), 32'h0);
        step();
        chk("f3_back_idle_stallreq", 32'(stallreq_o), 32'h1);
        chk_bus("f3_back_idle", 1'b0, 32'h0000_000C);
        step();

        // Fetch 4: flush coincident with ack discards the word.
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; flush_i = 1'b1; #1;
        chk_bus("f4_busy", 1'b1, 32'h0000_0008);
        chk("f4_flush_data", cpu_data_o, 32'h0);
        chk("f4_flush_stallreq", 32'(stallreq_o), 32'h0);
        step();
        wb_ack_i = 1'b0; flush_i = 1'b0; cpu_addr_i = 32'h0000_0140; #1;
        chk_bus("f4_dropped", 1'b0, 32'h0000_0008);
        chk("f4_rdbuf_cleared", cpu_data_o, 32'h0);
        chk("f4_refetch_stallreq", 32'(stallreq_o), 32'h1);
        step();
        chk_bus("f5_busy", 1'b1, 32'h0000_0140);

        // Async reset mid-BUSY.
        rst = 1'b0; #1;
        chk_bus("rst_mid", 1'b0, 32'h0);
        chk("rst_mid_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b1; cpu_addr_i = 32'h0000_0200; #1;
        chk("rst_rel_stallreq", 32'(stallreq_o), 32'h1);
        chk_bus("rst_rel_idle", 1'b0, 32'h0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; #1;
        chk_bus("f6_busy", 1'b1, 32'h0000_0200);
        chk("f6_ack_data", cpu_data_o, 32'hCAFE_F00D);
        step();

        // Chip disabled: no cycle, NOP output.
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0; #1;
        chk("ce0_data", cpu_data_o, 32'h0);
        chk("ce0_stallreq", 32'(stallreq_o), 32'h0);
        step();
        chk_bus("ce0_idle", 1'b0, 32'h0000_0200);
        step();
        chk_bus("ce0_idle2", 1'b0, 32'h0000_0200);

        // ce falls during BUSY: result still buffered.
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0300; step();
        cpu_ce_i = 1'b0; #1;
        chk_bus("cefall_busy", 1'b1, 32'h0000_0300);
        chk("cefall_stallreq", 32'(stallreq_o), 32'h1);
        chk("cefall_data", cpu_data_o, 32'h0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA; #1;
        chk("cefall_ack_data", cpu_data_o, 32'h0);
        step();

        // Ack held high into IDLE is ignored; new fetch still goes through IDLE.
        cpu_ce_i = 1'b1; wb_dat_i = 32'h0BAD_F00D; cpu_addr_i = 32'h0000_0400; #1;
        chk("hold_idle_data", cpu_data_o, 32'h55AA_55AA);
        chk("hold_idle_stallreq", 32'(stallreq_o), 32'h1);
        chk_bus("hold_idle", 1'b0, 32'h0000_0300);
        step();
        chk_bus("hold_busy", 1'b1, 32'h0000_0400);
        chk("hold_busy_data", cpu_data_o, 32'h0BAD_F00D);
        chk("hold_busy_stallreq", 32'(stallreq_o), 32'h0);
        step();
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0; #1;
        chk_bus("final_idle", 1'b0, 32'h0000_0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
